axis_rd_arbiter: RTL and testbench

- Round-robin scheduler that shares one IP_S_AXIS_MM2S read sink among NUM_REQ user-IP requesters.
- Grants one requester at a time and drives uip2axi_rd_en for that grant.
- Waits for axi2uip_rd_done, captures rd_buffer and returns it to the granted requester over a valid/ready response port.
- Sits between the aggregation/graph engines and the S_AXIS sink; guards against a stalled stream with a timeout.

---
 rtl/axis_rd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axis_rd_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rd_arbiter.sv
// Round-robin arbiter sharing one S_AXIS MM2S read sink among NUM_REQ requesters.
// One burst in flight at a time; a stalled sink is aborted after TIMEOUT_CYCLES with rsp_err set.
module axis_rd_arbiter #(
   parameter int NUM_REQ              = 4,
   parameter int READ_BURST_LEN       = 8,
   parameter int C_S_AXIS_TDATA_WIDTH = 128,
   parameter int TIMEOUT_CYCLES       = 1024,
   localparam int RD_BUF_LEN          = READ_BURST_LEN * C_S_AXIS_TDATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [RD_BUF_LEN-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  uip2axi_rd_en,
   input  logic                  axi2uip_rd_done,
   input  logic [RD_BUF_LEN-1:0] rd_buffer,
   output logic                  busy,
   output logic                  stray_done
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [IDW-1:0] ID_LAST    = IDW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DELIVER = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [IDW-1:0]        grant_id_reg, grant_id_next;
   logic [IDW-1:0]        last_grant_reg, last_grant_next;
   logic [TW-1:0]         timer_reg, timer_next;
   logic                  rd_en_reg, rd_en_next;
   logic [NUM_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
   logic [RD_BUF_LEN-1:0] rsp_data_reg, rsp_data_next;
   logic                  rsp_err_reg, rsp_err_next;
   logic                  stray_reg, stray_next;

   logic [IDW-1:0]     start_id;
   logic [NUM_REQ-1:0] req_rot;
   logic [IDW:0]       sel_sum;
   logic [IDW-1:0]     sel;
   logic               any_req;
   logic               accept;
   logic [NUM_REQ-1:0] grant_onehot;

   // Rotate the request vector so the requester after last_grant sits at bit 0,
   // take the lowest set bit, then rotate the index back.
   always_comb begin
      start_id = (last_grant_reg == ID_LAST) ? '0 : last_grant_reg + IDW'(1);
      req_rot  = NUM_REQ'({req_valid, req_valid} >> start_id);
      sel_sum  = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_rot[j])
            sel_sum = {1'b0, start_id} + (IDW+1)'(j);
      end
      if (sel_sum >= (IDW+1)'(NUM_REQ))
         sel_sum = sel_sum - (IDW+1)'(NUM_REQ);
      sel = sel_sum[IDW-1:0];
   end

   assign any_req = |req_valid;
   assign accept  = !rst && (state_reg == IDLE) && any_req;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_decode
         assign req_ready[gi]    = accept && (sel == IDW'(gi));
         assign grant_onehot[gi] = (grant_id_reg == IDW'(gi));
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      grant_id_next   = grant_id_reg;
      last_grant_next = last_grant_reg;
      timer_next      = timer_reg;
      rd_en_next      = rd_en_reg;
      rsp_valid_next  = rsp_valid_reg;
      rsp_data_next   = rsp_data_reg;
      rsp_err_next    = rsp_err_reg;
      stray_next      = stray_reg;

      // A done outside WAIT (e.g. a late one after timeout) is only flagged.
      if (axi2uip_rd_done && (state_reg != WAIT))
         stray_next = 1'b1;

      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next    = WAIT;
               grant_id_next = sel;
               timer_next    = '0;
               rd_en_next    = 1'b1;
            end
         end
         WAIT: begin
            if (timer_reg != '1)
               timer_next = timer_reg + TW'(1);
            if (axi2uip_rd_done) begin
               state_next     = DELIVER;
               rd_en_next     = 1'b0;
               rsp_data_next  = rd_buffer;
               rsp_err_next   = 1'b0;
               rsp_valid_next = grant_onehot;
            end else if (timer_reg == TIMER_LAST) begin
               state_next     = DELIVER;
               rd_en_next     = 1'b0;
               rsp_data_next  = '0;
               rsp_err_next   = 1'b1;
               rsp_valid_next = grant_onehot;
            end
         end
         DELIVER: begin
            if (rsp_ready[grant_id_reg]) begin
               state_next      = IDLE;
               rsp_valid_next  = '0;
               last_grant_next = grant_id_reg;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_id_reg   <= '0;
         last_grant_reg <= ID_LAST;
         timer_reg      <= '0;
         rd_en_reg      <= 1'b0;
         rsp_valid_reg  <= '0;
         rsp_data_reg   <= '0;
         rsp_err_reg    <= 1'b0;
         stray_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_id_reg   <= grant_id_next;
         last_grant_reg <= last_grant_next;
         timer_reg      <= timer_next;
         rd_en_reg      <= rd_en_next;
         rsp_valid_reg  <= rsp_valid_next;
         rsp_data_reg   <= rsp_data_next;
         rsp_err_reg    <= rsp_err_next;
         stray_reg      <= stray_next;
      end
   end

   assign rsp_valid     = rsp_valid_reg;
   assign rsp_data      = rsp_data_reg;
   assign rsp_err       = rsp_err_reg;
   assign uip2axi_rd_en = rd_en_reg;
   assign busy          = (state_reg != IDLE);
   assign stray_done    = stray_reg;

endmodule

// File: tb/tb_axis_rd_arbiter.sv
// Randomised bench for axis_rd_arbiter: driver plays requesters and sink, monitor consumes
// responses and checks grants/responses against queues filled from a round-robin model.
module tb_axis_rd_arbiter;
   localparam int NR  = 4;
   localparam int RBL = 2;
   localparam int TDW = 16;
   localparam int TO  = 16;
   localparam int BW  = RBL * TDW;

   logic          clk             = 1'b0;
   logic          rst             = 1'b1;
   logic [NR-1:0] req_valid       = '0;
   logic [NR-1:0] req_ready;
   logic [NR-1:0] rsp_valid;
   logic [NR-1:0] rsp_ready       = '0;
   logic [BW-1:0] rsp_data;
   logic          rsp_err;
   logic          uip2axi_rd_en;
   logic          axi2uip_rd_done = 1'b0;
   logic [BW-1:0] rd_buffer       = '0;
   logic          busy;
   logic          stray_done;

   always #5 clk = ~clk;

   axis_rd_arbiter #(
      .NUM_REQ             (NR),
      .READ_BURST_LEN      (RBL),
      .C_S_AXIS_TDATA_WIDTH(TDW),
      .TIMEOUT_CYCLES      (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .uip2axi_rd_en  (uip2axi_rd_en),
      .axi2uip_rd_done(axi2uip_rd_done),
      .rd_buffer      (rd_buffer),
      .busy           (busy),
      .stray_done     (stray_done)
   );

   typedef struct {
      int            id;
      logic [BW-1:0] data;
      logic          err;
   } rsp_t;

   int   n_checks    = 0;
   int   n_fail      = 0;
   int   grant_q[$];
   rsp_t rsp_q[$];
   int   last_model  = NR - 1;
   bit   stray_model = 1'b0;
   int   hold_cycles = 0;
   int   resp_count  = 0;
   int   txn_no      = 0;

   bit            mon_active = 1'b0;
   bit            mon_took   = 1'b0;
   int            mon_wait   = 0;
   int            mon_g;
   rsp_t          mon_cur;
   logic [NR-1:0] mon_r;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Round-robin rule: first requesting index after the last grant, wrapping.
   function automatic int model_pick(input logic [NR-1:0] mask, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (mask[(last + k) % NR])
            return (last + k) % NR;
      end
      return -1;
   endfunction

   // Monitor / response consumer: samples just after each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (req_ready !== '0) begin
            if (grant_q.size() == 0)
               chk("unexpected_grant", 64'(req_ready), 64'(0));
            else begin
               mon_g = grant_q.pop_front();
               chk("grant", 64'(req_ready), 64'(1) << mon_g);
            end
         end
         if (rst) begin
            mon_active = 1'b0;
            mon_took   = 1'b0;
         end else if (mon_active && mon_took) begin
            chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
            mon_active = 1'b0;
            mon_took   = 1'b0;
            resp_count++;
         end else if (mon_active) begin
            chk("rsp_valid_hold", 64'(rsp_valid), 64'(1) << mon_cur.id);
            chk("rsp_data_hold", 64'(rsp_data), 64'(mon_cur.data));
            chk("rsp_err_hold", 64'(rsp_err), 64'(mon_cur.err));
         end else if (rsp_valid !== '0) begin
            if (rsp_q.size() == 0)
               chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
            else begin
               mon_cur    = rsp_q.pop_front();
               mon_active = 1'b1;
               mon_wait   = 0;
               chk("rsp_valid", 64'(rsp_valid), 64'(1) << mon_cur.id);
               chk("rsp_data", 64'(rsp_data), 64'(mon_cur.data));
               chk("rsp_err", 64'(rsp_err), 64'(mon_cur.err));
            end
         end
         mon_r = NR'($urandom);
         if (mon_active) begin
            if (mon_wait < hold_cycles)
               mon_r[mon_cur.id] = 1'b0;
            mon_wait++;
            mon_took = mon_r[mon_cur.id];
         end
         rsp_ready = mon_r;
      end
   end

   // delay: rd_en cycle on which the sink pulses done (0 = never -> timeout).
   // late_wait: cycles after rd_en drops before a stray done (-1 = none).
   // rst_at: rd_en cycle at which reset is pulsed (0 = none).
   task automatic run_txn(input logic [NR-1:0] mask, input int delay, input logic [BW-1:0] data,
                          input int hold, input int late_wait, input int rst_at);
      int   g, n, n_exp, guard, c0;
      bit   tmo;
      rsp_t e;
      g     = model_pick(mask, last_model);
      tmo   = (delay == 0) || (delay > TO);
      n_exp = tmo ? TO : delay;
      @(negedge clk);
      hold_cycles = hold;
      c0 = resp_count;
      grant_q.push_back(g);
      if (rst_at == 0) begin
         e.id   = g;
         e.data = tmo ? '0 : data;
         e.err  = tmo;
         rsp_q.push_back(e);
      end
      req_valid = mask;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (uip2axi_rd_en !== 1'b1 && guard < 20);
      chk("accept_latency", 64'(guard), 64'(1));
      req_valid = '0;
      n = 0;
      while (uip2axi_rd_en === 1'b1 && n < 4 * TO) begin
         n++;
         if (n == rst_at) begin
            rst = 1'b1;
            break;
         end
         axi2uip_rd_done = (n == delay);
         rd_buffer       = (n == delay) ? data : BW'($urandom);
         @(negedge clk);
      end
      axi2uip_rd_done = 1'b0;
      if (rst_at != 0) begin
         @(negedge clk);
         rst = 1'b0;
         chk("rst_rd_en", 64'(uip2axi_rd_en), 64'(0));
         chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
         chk("rst_busy", 64'(busy), 64'(0));
         chk("rst_rsp_err", 64'(rsp_err), 64'(0));
         chk("rst_rsp_data", 64'(rsp_data), 64'(0));
         chk("rst_stray", 64'(stray_done), 64'(0));
         last_model  = NR - 1;
         stray_model = 1'b0;
         txn_no++;
         $display("txn %0d: mask %b grant %0d reset at rd_en cycle %0d", txn_no, mask, g, rst_at);
         return;
      end
      chk("rd_en_cycles", 64'(n), 64'(n_exp));
      if (late_wait >= 0) begin
         repeat (late_wait) @(negedge clk);
         axi2uip_rd_done = 1'b1;
         rd_buffer       = BW'($urandom);
         stray_model     = 1'b1;
         @(negedge clk);
         axi2uip_rd_done = 1'b0;
      end
      guard = 0;
      while (resp_count == c0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("rsp_handshake", 64'(resp_count - c0), 64'(1));
      chk("stray_done", 64'(stray_done), 64'(stray_model));
      chk("busy_idle", 64'(busy), 64'(0));
      last_model = g;
      txn_no++;
      $display("txn %0d: mask %b grant %0d rd_en %0d cycles err %0d hold %0d late %0d",
               txn_no, mask, g, n, tmo, hold, late_wait);
   endtask

   initial begin
      logic [NR-1:0] m;
      int            d;
      repeat (3) @(negedge clk);
      req_valid = '1;
      #1;
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rd_en", 64'(uip2axi_rd_en), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_stray", 64'(stray_done), 64'(0));
      chk("reset_rsp_err", 64'(rsp_err), 64'(0));
      chk("reset_rsp_data", 64'(rsp_data), 64'(0));
      req_valid = '0;
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_txn(4'b1111, 1 + int'($urandom_range(0, 7)), BW'($urandom), 0, -1, 0);
      run_txn(4'b0100, 10, {4{8'hA5}}, 0, -1, 0);
      run_txn(4'b0011, 5, BW'($urandom), 20, 3, 0);
      run_txn(4'b1000, 0, BW'($urandom), 0, 2, 0);
      run_txn(4'b0110, TO, BW'($urandom), 2, -1, 0);
      for (int i = 0; i < 30; i++) begin
         m = NR'($urandom_range(1, 15));
         d = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TO));
         run_txn(m, d, BW'($urandom), int'($urandom_range(0, 4)),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1, 0);
      end
      run_txn(4'b0100, 12, BW'($urandom), 0, -1, 5);
      run_txn(4'b1111, 3, BW'($urandom), 0, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
